// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// fields, datapath select codes and the bundled control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  // Which kind of ALU operation a state needs; the decoder turns this into alu_ctrl.
  typedef enum logic [1:0] {
    ALU_OP_NONE  = 2'd0,
    ALU_OP_ADD   = 2'd1,
    ALU_OP_SUB   = 2'd2,
    ALU_OP_FUNCT = 2'd3
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_control_decoder.sv
// Maps the current state's ALU operation class and the funct field to the
// ALU control code; flags funct values the ALU does not support.
module alu_control_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_illegal
);

  // States with no ALU use drive 000; funct is only looked at for R-type execute.
  always_comb begin
    alu_ctrl      = 3'b000;
    funct_illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory and
// write-back over a shared ALU and memory port, and counts retired instructions.
//
// Memory handshake: a memory state (FETCH, MEM_READ, MEM_WRITE) presents its
// request for as long as it is resident; mem_ready=1 in a cycle means the
// access completed in that cycle, so the state advances on that edge and the
// FETCH-only strobes (ir_write, pc_write) fire in that same cycle only.
// mem_ready is ignored in every other state.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  state_t           state_d;
  ctrl_t            c;
  ctrl_t            c_out;
  alu_op_t          alu_op;
  logic [2:0]       dec_alu_ctrl;
  logic             funct_illegal;
  logic [CNT_W-1:0] retired_q;

  // ALU operation class depends on state only, keeping the decoder off any loop.
  always_comb begin
    alu_op = ALU_OP_NONE;
    case (state_q)
      S_FETCH, S_DECODE, S_MEM_ADDR, S_ADDI_EX: alu_op = ALU_OP_ADD;
      S_BRANCH:                                 alu_op = ALU_OP_SUB;
      S_EXECUTE:                                alu_op = ALU_OP_FUNCT;
      default:                                  alu_op = ALU_OP_NONE;
    endcase
  end

  alu_control_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_ctrl      (dec_alu_ctrl),
    .funct_illegal (funct_illegal)
  );

  // Next-state and control decode; anything not set for a state stays 0.
  always_comb begin
    state_d    = S_FETCH;
    c          = '0;
    c.alu_ctrl = dec_alu_ctrl;
    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d      = S_FETCH;
            c.illegal    = 1'b1;
            c.instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_d     = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        state_d    = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (mem_ready) begin
          c.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        if (funct_illegal) begin
          c.illegal    = 1'b1;
          c.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      default: begin
        c       = '0;
        state_d = S_FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired counter: legal completions only, free-running wrap.
  always_ff @(posedge clock) begin
    if (reset)                          retired_q <= '0;
    else if (c.instr_done && !c.illegal) retired_q <= retired_q + CNT_W'(1);
  end

  // Every output is held at 0 while reset is high, so no strobe escapes an abort.
  assign c_out         = reset ? '0 : c;
  assign pc_write      = c_out.pc_write;
  assign pc_write_cond = c_out.pc_write_cond;
  assign i_or_d        = c_out.i_or_d;
  assign mem_read      = c_out.mem_read;
  assign mem_write     = c_out.mem_write;
  assign ir_write      = c_out.ir_write;
  assign reg_write     = c_out.reg_write;
  assign reg_dst       = c_out.reg_dst;
  assign mem_to_reg    = c_out.mem_to_reg;
  assign alu_src_a     = c_out.alu_src_a;
  assign alu_src_b     = c_out.alu_src_b;
  assign pc_source     = c_out.pc_source;
  assign alu_ctrl      = c_out.alu_ctrl;
  assign instr_done    = c_out.instr_done;
  assign illegal       = c_out.illegal;
  assign state         = reset ? 4'd0 : state_q;
  assign retired       = reset ? '0 : retired_q;

endmodule
